// File: rtl/axi_read_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin grant, single outstanding burst, R beats routed to owner.
// Optional burst-length checker enabled by defining AXI_ARB_LEN_CHECK_EN (err tied low otherwise).
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [LEN_WIDTH-1:0]  m0_req_len,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_data,
  output logic                  m0_rsp_last,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [LEN_WIDTH-1:0]  m1_req_len,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_data,
  output logic                  m1_rsp_last,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [LEN_WIDTH-1:0]  arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   grant0;
  logic   grant1;

  // Round-robin: on contention the requester that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (m0_req_valid && m1_req_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = m0_req_valid;
        grant1 = m1_req_valid;
      end
    end
  end

  assign m0_req_ready = grant0;
  assign m1_req_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      araddr     <= '0;
      arlen      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            araddr <= grant1 ? m1_req_addr : m0_req_addr;
            arlen  <= grant1 ? m1_req_len  : m0_req_len;
            owner  <= grant1;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (arready) state <= DATA;
        end
        DATA: begin
          if (rvalid && rlast) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arvalid = (state == ADDR);
  assign rready  = (state == DATA);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // R channel passes straight through to the owner; the other side sees zeros.
  assign m0_rsp_valid = rready && !owner && rvalid;
  assign m0_rsp_last  = rready && !owner && rvalid && rlast;
  assign m0_rsp_data  = (rready && !owner) ? rdata : '0;
  assign m1_rsp_valid = rready && owner && rvalid;
  assign m1_rsp_last  = rready && owner && rvalid && rlast;
  assign m1_rsp_data  = (rready && owner) ? rdata : '0;

`ifdef AXI_ARB_LEN_CHECK_EN
  logic [LEN_WIDTH:0] beat_cnt;
  logic [LEN_WIDTH:0] len_ext;

  assign len_ext = {1'b0, arlen};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ADDR && arready) begin
        beat_cnt <= '0;
      end else if (state == DATA && rvalid) begin
        beat_cnt <= beat_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
        if ((rlast && beat_cnt != len_ext) || (!rlast && beat_cnt == len_ext))
          err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grant order, AR hold, R routing, length error, mid-burst reset.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic        m0_req_ready, m1_req_ready;
  logic [31:0] m0_req_addr = '0, m1_req_addr = '0;
  logic [7:0]  m0_req_len = '0, m1_req_len = '0;
  logic        m0_rsp_valid, m1_rsp_valid, m0_rsp_last, m1_rsp_last;
  logic [31:0] m0_rsp_data, m1_rsp_data;
  logic        arvalid, arready = 1'b1;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready, rlast = 1'b0;
  logic [31:0] rdata = '0;
  logic        err;

  int total = 0;
  int bad   = 0;

`ifdef AXI_ARB_LEN_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  axi_read_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_len(m0_req_len), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
    .m0_rsp_last(m0_rsp_last),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_len(m1_req_len), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
    .m1_rsp_last(m1_rsp_last),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive nb beats from base; rlast on beat last_at (-1 = never). Checks routing on every beat.
  task automatic burst(input bit who, input int nb, input logic [31:0] base, input int last_at);
    for (int i = 0; i < nb; i++) begin
      rvalid = 1'b1;
      rdata  = base + i;
      rlast  = (i == last_at);
      #1;
      chk("rready_data", rready, 1'b1);
      chk("own_valid", who ? m1_rsp_valid : m0_rsp_valid, 1'b1);
      chk("own_data", who ? m1_rsp_data : m0_rsp_data, base + i);
      chk("own_last", who ? m1_rsp_last : m0_rsp_last, (i == last_at));
      chk("other_valid", who ? m0_rsp_valid : m1_rsp_valid, 1'b0);
      chk("other_last", who ? m0_rsp_last : m1_rsp_last, 1'b0);
      chk("other_data", who ? m0_rsp_data : m1_rsp_data, 32'h0);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arlen", arlen, 8'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid, m0_rsp_last, m1_rsp_last}, 4'b0);
    chk("arsize", arsize, 3'd2);
    chk("arburst", arburst, 2'd1);
    #10 rst_n = 1'b1;
    tick();

    // Single m0 burst, 8 beats
    m0_req_valid = 1'b1; m0_req_addr = 32'h1000; m0_req_len = 8'd7;
    #1;
    chk("t1_ready0", m0_req_ready, 1'b1);
    chk("t1_ready1", m1_req_ready, 1'b0);
    chk("t1_arvalid_idle", arvalid, 1'b0);
    tick();
    m0_req_addr = 32'hDEAD; m0_req_len = 8'd1;
    #1;
    chk("t1_ready_once", m0_req_ready, 1'b0);
    chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_araddr", araddr, 32'h1000);
    chk("t1_arlen", arlen, 8'd7);
    chk("t1_rready_addr", rready, 1'b0);
    m0_req_valid = 1'b0;
    tick();
    chk("t1_arvalid_drop", arvalid, 1'b0);
    burst(1'b0, 8, 32'hA0, 7);
    chk("t1_idle_rready", rready, 1'b0);
    chk("t1_err", err, 1'b0);

    // Fresh reset, simultaneous requests: m0 first, then m1 after one IDLE cycle
    rst_n = 1'b0; #1; rst_n = 1'b1;
    m0_req_valid = 1'b1; m0_req_addr = 32'h2000; m0_req_len = 8'd1;
    m1_req_valid = 1'b1; m1_req_addr = 32'h3000; m1_req_len = 8'd1;
    #1;
    chk("t2_ready0", m0_req_ready, 1'b1);
    chk("t2_ready1", m1_req_ready, 1'b0);
    tick();
    m0_req_valid = 1'b0;
    chk("t2_araddr0", araddr, 32'h2000);
    tick();
    burst(1'b0, 2, 32'hB0, 1);
    #1;
    chk("t2_idle_rready", rready, 1'b0);
    chk("t2_ready1_after", m1_req_ready, 1'b1);
    tick();
    m1_req_valid = 1'b0;
    chk("t2_araddr1", araddr, 32'h3000);
    tick();
    burst(1'b1, 2, 32'hC0, 1);

    // Both held pending across 4 bursts: alternate starting with m0 (m1 went last)
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    m0_req_len = 8'd0; m1_req_len = 8'd0;
    for (int k = 0; k < 4; k++) begin
      m0_req_addr = 32'h5000 + k;
      m1_req_addr = 32'h6000 + k;
      #1;
      chk("t3_ready0", m0_req_ready, (k % 2 == 0));
      chk("t3_ready1", m1_req_ready, (k % 2 == 1));
      tick();
      chk("t3_araddr", araddr, (k % 2 == 0) ? 32'h5000 + k : 32'h6000 + k);
      tick();
      burst(k[0], 1, 32'hD0 + k, 0);
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;

    // AR held by arready=0 for 3 cycles
    m0_req_valid = 1'b1; m0_req_addr = 32'h4000; m0_req_len = 8'd3;
    arready = 1'b0;
    tick();
    m0_req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t4_arvalid_hold", arvalid, 1'b1);
      chk("t4_araddr_hold", araddr, 32'h4000);
      chk("t4_arlen_hold", arlen, 8'd3);
      chk("t4_rready_hold", rready, 1'b0);
      tick();
    end
    arready = 1'b1;
    #1;
    chk("t4_arvalid_4th", arvalid, 1'b1);
    tick();
    chk("t4_data_entered", rready, 1'b1);
    chk("t4_arvalid_drop", arvalid, 1'b0);
    burst(1'b0, 4, 32'hE0, 3);
    chk("t4_err", err, 1'b0);

    // Early rlast on beat 5 of an 8-beat burst
    m1_req_valid = 1'b1; m1_req_addr = 32'h7000; m1_req_len = 8'd7;
    tick();
    m1_req_valid = 1'b0;
    tick();
    burst(1'b1, 5, 32'hF0, 4);
    chk("t5_err", err, ERR_EXP);
    chk("t5_idle", rready, 1'b0);
    tick();
    chk("t5_err_sticky", err, ERR_EXP);

    // Reset asserted mid-DATA on beat 3
    m0_req_valid = 1'b1; m0_req_addr = 32'h8000; m0_req_len = 8'd7;
    tick();
    m0_req_valid = 1'b0;
    tick();
    burst(1'b0, 3, 32'h90, -1);
    rvalid = 1'b1; rdata = 32'h93;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rready", rready, 1'b0);
    chk("t6_arvalid", arvalid, 1'b0);
    chk("t6_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 2'b00);
    chk("t6_err", err, 1'b0);
    rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    m1_req_valid = 1'b1; m1_req_addr = 32'h9000; m1_req_len = 8'd1;
    #1;
    chk("t6_ready1", m1_req_ready, 1'b1);
    tick();
    m1_req_valid = 1'b0;
    chk("t6_araddr", araddr, 32'h9000);
    chk("t6_arlen", arlen, 8'd1);
    tick();
    burst(1'b1, 2, 32'h60, 1);
    chk("t6_err_end", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI4 read channel (AR + R) between two burst requesters: requester 0 (icache line refill) and requester 1 (dcache line refill).
- Grants one request at a time and drives its AR phase downstream.
- Routes every R beat of that burst back to the owning requester only.
- Sits between the cache cores and the single memory-side read port of the core.

Parameters:
ADDR_WIDTH, 32, address width of requests and araddr
DATA_WIDTH, 32, width of rdata and the response data ports
LEN_WIDTH, 8, width of the burst length field (beats minus 1)

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  reset, asynchronous, active-low
m0_req_valid  input  1  requester 0 burst request; held until m0_req_ready
m0_req_ready  output  1  one-cycle pulse: requester 0 request accepted
m0_req_addr  input  ADDR_WIDTH  requester 0 burst start address
m0_req_len  input  LEN_WIDTH  requester 0 beats minus 1
m0_rsp_valid  output  1  requester 0 response beat valid
m0_rsp_data  output  DATA_WIDTH  requester 0 response beat data
m0_rsp_last  output  1  requester 0 final beat
m1_req_valid, m1_req_ready, m1_req_addr, m1_req_len, m1_rsp_valid, m1_rsp_data, m1_rsp_last  same as m0_*, for requester 1
arvalid  output  1  AXI read address valid
arready  input  1  AXI read address ready
araddr  output  ADDR_WIDTH  AXI read address
arlen  output  LEN_WIDTH  AXI burst length
arsize  output  3  fixed 3'b010 (4 bytes per beat)
arburst  output  2  fixed 2'b01 (INCR)
rvalid  input  1  AXI read data valid
rready  output  1  AXI read data ready
rdata  input  DATA_WIDTH  AXI read data
rlast  input  1  AXI last beat
err  output  1  sticky burst-length error (see Optional Feature)

Behaviour:
- States: IDLE, ADDR, DATA. Reset state is IDLE.
- Reset values:
  - araddr=0, arlen=0, owner=0, last_grant=1, err=0.
  - All valid, ready and last outputs are 0.
  - arsize and arburst are constants and ignore reset.
- IDLE:
  - If either req_valid is 1, pick a winner:
    - Only one request pending: that requester wins.
    - Both pending: the requester that is not last_grant wins (round-robin). After reset, requester 0 wins first.
  - In the same cycle: pulse winner's req_ready=1, latch its addr into araddr and its len into arlen, set owner, move to ADDR.
  - The loser's req_ready stays 0. It must keep req_valid asserted.
- ADDR:
  - arvalid=1. araddr and arlen are registered and stable.
  - On arvalid&&arready, move to DATA. arvalid drops the next cycle.
- DATA:
  - rready=1, combinational.
  - The owner's rsp_valid, rsp_data and rsp_last equal rvalid, rdata and rlast in the same cycle (zero latency).
  - The non-owner's rsp_valid and rsp_last are 0. Its rsp_data is don't-care and is driven 0.
  - On rvalid&&rlast: move to IDLE and set last_grant=owner.
- rready=0 and arvalid=0 in IDLE. rready=0 in ADDR; R beats during ADDR are illegal.
- Minimum turnaround: the next request is granted in the IDLE cycle after rlast, so there is at least one dead cycle between bursts.
- Request fields are sampled only at grant. Changes to req_addr or req_len after req_ready are ignored.
- Asynchronous reset in any state:
  - Forces IDLE immediately and drops all handshakes.
  - The downstream slave shares rst_n, so no burst is left dangling.
- Requester 1 pending while requester 0 re-requests every turnaround: grants alternate 0,1,0,1. There is no starvation.

Optional Feature:
Macro: AXI_ARB_LEN_CHECK_EN
- Defined:
  - A beat counter of LEN_WIDTH+1 bits clears on entering DATA and increments on each rvalid beat.
  - err sets (sticky until reset) when either:
    - rlast arrives with counter != latched arlen, or
    - a beat arrives with counter == arlen and rlast=0.
  - State transitions are unchanged; rlast alone ends the burst.
- Not defined: no counter; err is tied to 0.

Test Plan:
- Reset, then m0 request addr=0x1000, len=7, arready=1 → m0_req_ready pulses once; arvalid=1 next cycle with araddr=0x1000, arlen=7, arsize=2, arburst=1. 8 beats 0xA0..0xA7 appear on m0_rsp_data; m0_rsp_last only on 0xA7; m1_rsp_valid stays 0.
- Both requests in the same cycle after reset (m0 addr=0x2000, m1 addr=0x3000) → m0 granted first (araddr=0x2000). After its rlast, one IDLE cycle, then m1 granted (araddr=0x3000).
- m0 re-requests immediately after each grant while m1 is held pending → grant order is m0, m1, m0, m1 over 4 bursts.
- arready held 0 for 3 cycles in ADDR → arvalid stays 1 and araddr/arlen stay stable for 4 cycles; DATA is entered only after arready=1.
- With AXI_ARB_LEN_CHECK_EN, len=7 and rlast on beat 5 → err=1 from the next cycle and stays 1; state returns to IDLE. Without the macro, err=0.
- rst_n pulsed low mid-DATA (beat 3) → same cycle: rready=0, arvalid=0, all rsp_valid=0, err=0. After release, a fresh m1 request is granted normally.
